// File: rtl/gpio_vector_gen.sv
// gpio_vector_gen: drives an up-counting value onto a slice of the GPIO
// vector, holding each value for DIVIDE clocks. IDLE leaves the pads
// released, RUN drives the count, and DONE keeps END_VALUE on the pins.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | field released (oeb=1, out=0), waiting for start
// RUN   | field driven with the count, prescaler advancing while enable=1
// DONE  | field driven with END_VALUE, waiting for a restart

module gpio_vector_gen #(
  parameter int GPIO_WIDTH  = 44,
  parameter int FIELD_LSB   = 16,
  parameter int FIELD_WIDTH = 8,
  parameter int DIVIDE      = 1000,
  parameter int END_VALUE   = 33,
  parameter bit WRAP        = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   enable,
  output logic [GPIO_WIDTH-1:0]  gpio_out,
  output logic [GPIO_WIDTH-1:0]  gpio_oeb,
  output logic                   busy,
  output logic                   done,
  output logic [FIELD_WIDTH-1:0] count
);

  localparam int PRE_W = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [PRE_W-1:0]       PRE_LAST = PRE_W'(DIVIDE - 1);
  localparam logic [FIELD_WIDTH-1:0] END_CNT  = FIELD_WIDTH'(END_VALUE);
  localparam logic [GPIO_WIDTH-1:0]  ONE_G    = {{(GPIO_WIDTH-1){1'b0}}, 1'b1};
  // Ones over the driven field; the subtraction also covers a field that
  // spans the whole vector, where the shift wraps to zero.
  localparam logic [GPIO_WIDTH-1:0]  FIELD_MASK =
    ((ONE_G << FIELD_WIDTH) - ONE_G) << FIELD_LSB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [PRE_W-1:0]       prescaler;
  logic [FIELD_WIDTH-1:0] value;

  // Sequencer and output registers. Outputs reflect the state held before
  // the edge, so a value becomes visible one clock after it is loaded;
  // abort releases the pads on the same edge it is sampled.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      prescaler <= '0;
      value     <= '0;
      gpio_out  <= '0;
      gpio_oeb  <= '1;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
    end else begin
      if (abort || state == IDLE) begin
        gpio_out <= '0;
        gpio_oeb <= '1;
        busy     <= 1'b0;
        done     <= 1'b0;
        count    <= '0;
      end else begin
        gpio_out <= GPIO_WIDTH'(value) << FIELD_LSB;
        gpio_oeb <= ~FIELD_MASK;
        busy     <= (state == RUN);
        done     <= (state == DONE);
        count    <= value;
      end

      if (abort) begin
        state     <= IDLE;
        prescaler <= '0;
        value     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= RUN;
              prescaler <= '0;
              value     <= '0;
            end
          end
          RUN: begin
            if (enable) begin
              if (prescaler == PRE_LAST) begin
                prescaler <= '0;
                if (value != END_CNT) begin
                  value <= value + 1'b1;
                end else if (WRAP) begin
                  value <= '0;
                end else begin
                  state <= DONE;
                end
              end else begin
                prescaler <= prescaler + 1'b1;
              end
            end
          end
          DONE: begin
            if (start) begin
              state     <= RUN;
              prescaler <= '0;
              value     <= '0;
            end
          end
          default: begin
            state     <= IDLE;
            prescaler <= '0;
            value     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpio_vector_gen.sv
// Bench for gpio_vector_gen: four differently configured instances share one
// stimulus stream and are compared every clock against a reference model.
module tb_gpio_vector_gen;

  localparam int N = 4;
  localparam int GW = 44;
  localparam int DIVS  [N] = '{1000, 2, 1, 4};
  localparam int ENDS  [N] = '{33, 3, 255, 9};
  localparam int WRAPS [N] = '{0, 1, 1, 0};
  localparam int LSBS  [N] = '{16, 4, 36, 0};
  localparam int FWS   [N] = '{8, 4, 8, 6};
  localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2;

  logic clock = 1'b0;
  logic reset, start, abort, enable;

  logic [GW-1:0] g_out [N];
  logic [GW-1:0] g_oeb [N];
  logic [N-1:0]  busy_v, done_v;
  logic [7:0] c0;
  logic [3:0] c1;
  logic [7:0] c2;
  logic [5:0] c3;

  longint o_out [N], o_oeb [N], o_cnt [N], o_busy [N], o_done [N];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  longint m_st [N], m_pre [N], m_cnt [N];
  longint e_out [N], e_oeb [N], e_cnt [N], e_busy [N], e_done [N];

  always #5 clock = ~clock;

  gpio_vector_gen #(.GPIO_WIDTH(44), .FIELD_LSB(16), .FIELD_WIDTH(8), .DIVIDE(1000),
                    .END_VALUE(33), .WRAP(1'b0)) u0 (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .enable(enable),
    .gpio_out(g_out[0]), .gpio_oeb(g_oeb[0]), .busy(busy_v[0]), .done(done_v[0]), .count(c0));
  gpio_vector_gen #(.GPIO_WIDTH(44), .FIELD_LSB(4), .FIELD_WIDTH(4), .DIVIDE(2),
                    .END_VALUE(3), .WRAP(1'b1)) u1 (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .enable(enable),
    .gpio_out(g_out[1]), .gpio_oeb(g_oeb[1]), .busy(busy_v[1]), .done(done_v[1]), .count(c1));
  gpio_vector_gen #(.GPIO_WIDTH(44), .FIELD_LSB(36), .FIELD_WIDTH(8), .DIVIDE(1),
                    .END_VALUE(255), .WRAP(1'b1)) u2 (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .enable(enable),
    .gpio_out(g_out[2]), .gpio_oeb(g_oeb[2]), .busy(busy_v[2]), .done(done_v[2]), .count(c2));
  gpio_vector_gen #(.GPIO_WIDTH(44), .FIELD_LSB(0), .FIELD_WIDTH(6), .DIVIDE(4),
                    .END_VALUE(9), .WRAP(1'b0)) u3 (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .enable(enable),
    .gpio_out(g_out[3]), .gpio_oeb(g_oeb[3]), .busy(busy_v[3]), .done(done_v[3]), .count(c3));

  always_comb begin
    for (int i = 0; i < N; i++) begin
      o_out[i]  = longint'(g_out[i]);
      o_oeb[i]  = longint'(g_oeb[i]);
      o_busy[i] = longint'(busy_v[i]);
      o_done[i] = longint'(done_v[i]);
    end
    o_cnt[0] = longint'(c0);
    o_cnt[1] = longint'(c1);
    o_cnt[2] = longint'(c2);
    o_cnt[3] = longint'(c3);
  end

  task automatic chk(input string tag, input int inst, input longint obs, input longint exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s u%0d cycle %0d: observed=%0h expected=%0h", tag, inst, cyc, obs, exp);
    end
  endtask

  // Reference: pins show the sequence state held before each edge; abort and
  // reset release the pins immediately.
  task automatic model_step();
    longint all_ones, fmask;
    all_ones = (64'd1 << GW) - 1;
    for (int i = 0; i < N; i++) begin
      fmask = ((64'd1 << FWS[i]) - 1) << LSBS[i];
      if (reset) begin
        m_st[i] = S_IDLE; m_pre[i] = 0; m_cnt[i] = 0;
        e_out[i] = 0; e_oeb[i] = all_ones; e_busy[i] = 0; e_done[i] = 0; e_cnt[i] = 0;
      end else begin
        if (abort || m_st[i] == S_IDLE) begin
          e_out[i] = 0; e_oeb[i] = all_ones; e_busy[i] = 0; e_done[i] = 0; e_cnt[i] = 0;
        end else begin
          e_out[i]  = m_cnt[i] << LSBS[i];
          e_oeb[i]  = all_ones & ~fmask;
          e_busy[i] = (m_st[i] == S_RUN) ? 1 : 0;
          e_done[i] = (m_st[i] == S_DONE) ? 1 : 0;
          e_cnt[i]  = m_cnt[i];
        end
        if (abort) begin
          m_st[i] = S_IDLE; m_pre[i] = 0; m_cnt[i] = 0;
        end else if (m_st[i] != S_RUN) begin
          if (start) begin m_st[i] = S_RUN; m_pre[i] = 0; m_cnt[i] = 0; end
        end else if (enable) begin
          m_pre[i] = m_pre[i] + 1;
          if (m_pre[i] == DIVS[i]) begin
            m_pre[i] = 0;
            if (m_cnt[i] < ENDS[i]) m_cnt[i] = m_cnt[i] + 1;
            else if (WRAPS[i] != 0) m_cnt[i] = 0;
            else m_st[i] = S_DONE;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      chk("gpio_out", i, o_out[i], e_out[i]);
      chk("gpio_oeb", i, o_oeb[i], e_oeb[i]);
      chk("busy", i, o_busy[i], e_busy[i]);
      chk("done", i, o_done[i], e_done[i]);
      chk("count", i, o_cnt[i], e_cnt[i]);
    end
  endtask

  initial begin
    int n;
    longint all_ones;
    all_ones = (64'd1 << GW) - 1;
    for (int i = 0; i < N; i++) begin
      m_st[i] = S_IDLE; m_pre[i] = 0; m_cnt[i] = 0;
    end
    reset = 1'b1; start = 1'b0; abort = 1'b0; enable = 1'b0;

    // reset, then idle until the start pulse at cycle 10
    repeat (3) tick();
    chk("reset_oeb", 0, o_oeb[0], all_ones);
    chk("reset_busy", 0, o_busy[0], 0);
    reset = 1'b0;
    enable = 1'b1;
    repeat (6) tick();
    start = 1'b1;
    tick();
    start = 1'b0;

    // default configuration runs to DONE
    for (int k = 1; k <= 34005; k++) begin
      tick();
      if (k == 1 || k == 1000 || k == 1001 || k == 2001 || k == 33001)
        chk("p1_count", 0, o_cnt[0], longint'((k - 1) / 1000));
      if (k == 1) chk("p1_field_oeb", 0, (o_oeb[0] >> 16) & 255, 0);
      if (k == 34000) chk("p1_done_early", 0, o_done[0], 0);
      if (k == 34001) chk("p1_done", 0, o_done[0], 1);
      if (k == 34001) chk("p1_hold", 0, (o_out[0] >> 16) & 255, 33);
      chk("wrap_no_done", 1, o_done[1], 0);
    end

    // start pulse: restarts u0 from DONE, ignored by running instances
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("restart_cnt", 0, o_cnt[0], 0);
    chk("restart_busy", 0, o_busy[0], 1);
    chk("restart_done", 0, o_done[0], 0);
    repeat (20) tick();

    // enable dropped for 10 cycles at count 5 / prescaler 2 on u3
    abort = 1'b1; tick(); abort = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!(m_st[3] == S_RUN && m_cnt[3] == 5 && m_pre[3] == 2) && n < 200) begin
      tick(); n++;
    end
    chk("wait_c5_timeout", 3, longint'(n < 200), 1);
    enable = 1'b0;
    repeat (10) tick();
    chk("frozen_cnt", 3, o_cnt[3], 5);
    enable = 1'b1;
    tick(); tick();
    chk("pre_resume_cnt", 3, o_cnt[3], 5);
    tick();
    chk("step_after_freeze", 3, o_cnt[3], 6);

    // abort mid-run at count 7
    n = 0;
    while (o_cnt[3] != 7 && n < 100) begin tick(); n++; end
    chk("wait_c7_timeout", 3, longint'(n < 100), 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_oeb", 3, o_oeb[3], all_ones);
    chk("abort_cnt", 3, o_cnt[3], 0);
    chk("abort_busy", 3, o_busy[3], 0);
    repeat (5) tick();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("restart_after_abort", 3, o_cnt[3], 0);
    chk("restart_after_abort_busy", 3, o_busy[3], 1);

    // start and abort together from IDLE
    abort = 1'b1; tick();
    start = 1'b1; tick();
    start = 1'b0; abort = 1'b0;
    tick(); tick();
    chk("start_abort_busy", 2, o_busy[2], 0);
    chk("start_abort_oeb", 2, o_oeb[2], all_ones);

    // reset at count 20 (u2, one count per clock)
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (o_cnt[2] != 20 && n < 100) begin tick(); n++; end
    chk("wait_c20_timeout", 2, longint'(n < 100), 1);
    reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
    chk("mid_reset_cnt", 2, o_cnt[2], 0);
    chk("mid_reset_oeb", 2, o_oeb[2], all_ones);
    chk("mid_reset_busy", 2, o_busy[2], 0);
    chk("mid_reset_done", 2, o_done[2], 0);

    // DONE then start on u3
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (o_done[3] != 1 && n < 200) begin tick(); n++; end
    chk("wait_done_timeout", 3, longint'(n < 200), 1);
    chk("done_hold", 3, o_cnt[3], 9);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("done_restart_cnt", 3, o_cnt[3], 0);
    chk("done_restart_busy", 3, o_busy[3], 1);
    chk("done_restart_done", 3, o_done[3], 0);

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      start  = ($urandom_range(0, 19) == 0);
      abort  = ($urandom_range(0, 99) == 0);
      enable = ($urandom_range(0, 4) != 0);
      reset  = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
